prog_timer: RTL

PROG_TIMER -- requirements
Module: prog_timer

---
 rtl/prog_timer_pkg.sv | 12 +
 rtl/prog_timer_tick_prescaler.sv | 29 ++
 rtl/prog_timer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/prog_timer_pkg.sv
// Shared state encoding and mode constants for the programmable timer.
package prog_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/prog_timer_tick_prescaler.sv
// Base-tick prescaler: counts 0..PRESCALE-1 while enabled, Wrap marks the P-1 -> 0 step.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 100
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic Wrap
);

  logic [15:0] count_q, count_d;

  // Wrap is decoded from the count so the top can act on the same edge the count wraps.
  assign Wrap = Enable && (count_q == 16'(PRESCALE - 1));

  always_comb begin
    count_d = count_q;
    if (Clear)       count_d = '0;
    else if (Wrap)   count_d = '0;
    else if (Enable) count_d = count_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable one-shot / periodic timer counting in prescaled base ticks.
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int unsigned WIDTH      = 20,
  parameter int unsigned PRESCALE   = 100,
  parameter int unsigned DEF_PERIOD = 40
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Mode,
  input  logic [WIDTH-1:0] Period,
  output logic             Tick,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic [WIDTH-1:0] Remaining
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             presc_clr;
  logic             wrap;
  logic             start_ok, start_bad, expire;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clear  (presc_clr),
    .Enable (state_q == RUN),
    .Wrap   (wrap)
  );

  // Stop masks Start entirely, so a simultaneous pair never raises Err.
  assign start_ok  = Start && !Stop && (Period != '0);
  assign start_bad = Start && !Stop && (Period == '0);
  assign expire    = (state_q == RUN) && wrap && (rem_q == WIDTH'(1));

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    mode_d    = mode_q;
    rem_d     = rem_q;
    tick_d    = 1'b0;
    done_d    = done_q;
    err_d     = 1'b0;
    presc_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d   = RUN;
          period_d  = Period;
          mode_d    = Mode;
          rem_d     = Period;
          done_d    = 1'b0;
          presc_clr = 1'b1;
        end else if (start_bad) begin
          err_d = 1'b1;
        end
      end
      RUN: begin
        if (Stop) begin
          state_d   = IDLE;
          rem_d     = '0;
          presc_clr = 1'b1;
        end else begin
          tick_d = expire;
          if (start_ok) begin
            period_d  = Period;
            mode_d    = Mode;
            rem_d     = Period;
            done_d    = 1'b0;
            presc_clr = 1'b1;
          end else begin
            err_d = start_bad;
            if (expire) begin
              if (mode_q == MODE_PERIODIC) begin
                rem_d = period_q;
              end else begin
                state_d   = IDLE;
                rem_d     = '0;
                done_d    = 1'b1;
                presc_clr = 1'b1;
              end
            end else if (wrap) begin
              rem_d = rem_q - WIDTH'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      period_q <= WIDTH'(DEF_PERIOD);
      mode_q   <= MODE_ONESHOT;
      rem_q    <= '0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign Tick      = tick_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Err       = err_q;
  assign Remaining = rem_q;

endmodule
